// File: rtl/fc_buf_pkg.sv
// fc_buf_pkg: shared bank type, address split helpers and configuration check for the ping-pong buffer
package fc_buf_pkg;
  typedef logic bank_t;
  function automatic int unsigned lane_of(int unsigned addr, int unsigned lanes);
    return addr % lanes;
  endfunction
  function automatic int unsigned row_of(int unsigned addr, int unsigned lanes);
    return addr / lanes;
  endfunction
  function automatic bit cfg_ok(int unsigned depth, int unsigned lanes);
    return lanes >= 1 && (lanes & (lanes - 1)) == 0 && depth % lanes == 0 && depth / lanes >= 2;
  endfunction
endpackage

// File: rtl/fc_lane_ram.sv
// fc_lane_ram: one lane of one bank, simple dual-port RAM with enabled registered read
module fc_lane_ram #(
  parameter int WIDTH = 8,
  parameter int ROWS = 256,
  parameter int RAW = 8
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [RAW-1:0]   waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [RAW-1:0]   raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [ROWS];
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/fc_pingpong_buffer.sv
// fc_pingpong_buffer: two-bank activation buffer, word-wide fill on one bank, LANES-wide drain on the other
module fc_pingpong_buffer
  import fc_buf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1024,
  parameter int LANES = 4,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_en_i,
  input  logic [AW-1:0]          wr_addr_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic                   wr_last_i,
  output logic                   wr_ready_o,
  output logic                   rd_bank_valid_o,
  output logic [AW:0]            rd_len_o,
  input  logic                   rd_en_i,
  input  logic [$clog2(DEPTH)-$clog2(LANES)-1:0] rd_addr_i,
  output logic [LANES*WIDTH-1:0] rd_data_o,
  output logic                   rd_data_valid_o,
  input  logic                   rd_done_i,
  output logic                   err_o
);
  localparam int RAW = $clog2(DEPTH) - $clog2(LANES);
  localparam int LW = LANES * WIDTH;
  if (!cfg_ok(DEPTH, LANES) || AW < $clog2(DEPTH)) begin : g_bad_cfg
    $fatal(1, "fc_pingpong_buffer: illegal DEPTH/LANES/AW combination");
  end
  logic [1:0] full_q, full_d;
  bank_t wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d, rd_bank_q;
  logic [AW:0] wr_cnt_q, wr_cnt_d;
  logic [AW:0] len_q [2];
  logic [AW:0] len_d [2];
  logic err_q, rd_vld_q, has_q, accept, rd_fire, release_bank;
  logic [RAW-1:0] wr_row;
  logic [2*LW-1:0] dout;
  assign wr_ready_o = !full_q[wr_sel_q];
  assign accept = wr_en_i && wr_ready_o && (32'(wr_addr_i) < DEPTH);
  assign rd_bank_valid_o = full_q[rd_sel_q];
  assign rd_fire = rd_en_i && rd_bank_valid_o;
  assign release_bank = rd_done_i && rd_bank_valid_o;
  assign rd_len_o = rd_bank_valid_o ? len_q[rd_sel_q] : '0;
  assign wr_row = RAW'(row_of(32'(wr_addr_i), LANES));
  assign err_o = err_q;
  assign rd_data_valid_o = rd_vld_q;
  // bank captured at read time, so a same-cycle release does not switch the displayed data
  assign rd_data_o = has_q ? (rd_bank_q ? dout[2*LW-1:LW] : dout[LW-1:0]) : '0;
  always_comb begin
    full_d = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    len_d = len_q;
    wr_cnt_d = accept ? wr_cnt_q + {{AW{1'b0}}, 1'b1} : wr_cnt_q;
    if (accept && wr_last_i) begin
      full_d[wr_sel_q] = 1'b1;
      len_d[wr_sel_q] = wr_cnt_q + {{AW{1'b0}}, 1'b1};
      wr_cnt_d = '0;
      wr_sel_d = !wr_sel_q;
    end
    if (release_bank) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d = !rd_sel_q;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      wr_cnt_q <= '0;
      len_q <= '{default: '0};
      err_q <= 1'b0;
      rd_vld_q <= 1'b0;
      has_q <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      full_q <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      wr_cnt_q <= wr_cnt_d;
      len_q <= len_d;
      err_q <= err_q || (wr_en_i && !accept);
      rd_vld_q <= rd_fire;
      if (rd_fire) begin
        has_q <= 1'b1;
        rd_bank_q <= rd_sel_q;
      end
    end
  end
  for (genvar b = 0; b < 2; b++) begin : g_bank
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      fc_lane_ram #(.WIDTH(WIDTH), .ROWS(DEPTH / LANES), .RAW(RAW)) u_ram (
        .clk_i   (clk_i),
        .we_i    (accept && wr_sel_q == 1'(b) && lane_of(32'(wr_addr_i), LANES) == k),
        .waddr_i (wr_row),
        .wdata_i (wr_data_i),
        .re_i    (rd_fire && !rst_i && rd_sel_q == 1'(b)),
        .raddr_i (rd_addr_i),
        .rdata_o (dout[(b*LANES+k)*WIDTH +: WIDTH])
      );
    end
  end
endmodule

// File: tb/tb_fc_pingpong_buffer.sv
// tb_fc_pingpong_buffer: directed checks of fill, drain, handover, drops and reset at WIDTH=8 DEPTH=16 LANES=4
module tb_fc_pingpong_buffer;
  logic clk = 1'b0, rst, wr_en, wr_last, wr_ready, rd_bank_valid, rd_en, rd_data_valid, rd_done, err;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic [5:0] rd_len;
  logic [1:0] rd_addr;
  logic [31:0] rd_data;
  int total = 0, bad = 0;
  fc_pingpong_buffer #(.WIDTH(8), .DEPTH(16), .LANES(4), .AW(5)) dut (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_last_i(wr_last), .wr_ready_o(wr_ready), .rd_bank_valid_o(rd_bank_valid), .rd_len_o(rd_len),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_data_valid_o(rd_data_valid),
    .rd_done_i(rd_done), .err_o(err)
  );
  always #5 clk = !clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [4:0] a, input logic [7:0] d, input logic last);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_last = last;
    tick;
    wr_en = 1'b0; wr_last = 1'b0;
  endtask
  task automatic rd(input logic [1:0] row, input logic done);
    rd_en = 1'b1; rd_addr = row; rd_done = done;
    tick;
    rd_en = 1'b0; rd_done = 1'b0;
  endtask
  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_last = 1'b0;
    rd_en = 1'b0; rd_addr = '0; rd_done = 1'b0;
    tick; tick;
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_valid", rd_bank_valid, 0);
    chk("rst_len", rd_len, 0);
    chk("rst_dvalid", rd_data_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_data", rd_data, 0);
    rst = 1'b0;
    tick;
    // fill bank0 with 8 words
    for (int a = 0; a < 8; a++) wr(5'(a), 8'(8'h10 + a), a == 7);
    chk("b0_valid", rd_bank_valid, 1);
    chk("b0_len", rd_len, 8);
    chk("b0_wr_ready", wr_ready, 1);
    rd(2'd1, 1'b0);
    chk("b0_row1", rd_data, 32'h17161514);
    chk("b0_row1_dvalid", rd_data_valid, 1);
    tick;
    chk("idle_dvalid", rd_data_valid, 0);
    chk("idle_hold", rd_data, 32'h17161514);
    // fill bank1 completely while bank0 is still held
    for (int a = 0; a < 16; a++) wr(5'(a), 8'(8'hA0 + a), a == 15);
    chk("both_full_wr_ready", wr_ready, 0);
    chk("both_full_len", rd_len, 8);
    wr(5'd3, 8'hEE, 1'b1);
    chk("full_drop_err", err, 1);
    chk("full_drop_len", rd_len, 8);
    chk("pre_done_wr_ready", wr_ready, 0);
    rd(2'd0, 1'b1);
    chk("rd_done_data", rd_data, 32'h13121110);
    chk("rd_done_dvalid", rd_data_valid, 1);
    chk("rd_done_valid", rd_bank_valid, 1);
    chk("rd_done_len", rd_len, 16);
    chk("rd_done_wr_ready", wr_ready, 1);
    rd(2'd0, 1'b0);
    chk("b1_row0", rd_data, 32'hA3A2A1A0);
    rd(2'd3, 1'b0);
    chk("b1_row3", rd_data, 32'hAFAEADAC);
    rd_done = 1'b1;
    tick;
    rd_done = 1'b0;
    chk("b1_release_valid", rd_bank_valid, 0);
    chk("b1_release_len", rd_len, 0);
    // fresh reset so the out-of-range drop is visible on err
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst2_err", err, 0);
    chk("rst2_data", rd_data, 0);
    wr(5'd16, 8'hEE, 1'b1);
    chk("oor_err", err, 1);
    chk("oor_valid", rd_bank_valid, 0);
    chk("oor_wr_ready", wr_ready, 1);
    rd(2'd0, 1'b0);
    chk("rd_invalid_dvalid", rd_data_valid, 0);
    chk("rd_invalid_data", rd_data, 0);
    for (int a = 0; a < 4; a++) wr(5'(a), 8'(8'h30 + a), a == 3);
    chk("oor_len", rd_len, 4);
    rd(2'd0, 1'b0);
    chk("b0_new_row0", rd_data, 32'h33323130);
    // partial fill of bank1, then reset together with a read
    for (int a = 0; a < 3; a++) wr(5'(a), 8'(8'h50 + a), 1'b0);
    rst = 1'b1; rd_en = 1'b1; rd_addr = 2'd0;
    tick;
    rst = 1'b0; rd_en = 1'b0;
    chk("rst_rd_dvalid", rd_data_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", rd_bank_valid, 0);
    for (int a = 0; a < 4; a++) wr(5'(a), 8'(8'h60 + a), a == 3);
    chk("rewrite_len", rd_len, 4);
    rd(2'd0, 1'b0);
    chk("rewrite_row0", rd_data, 32'h63626160);
    rd(2'd1, 1'b0);
    chk("stale_row1", rd_data, 32'h17161514);
    // last write into bank1 in the same edge as release of bank0
    wr(5'd0, 8'h70, 1'b0);
    wr_en = 1'b1; wr_addr = 5'd1; wr_data = 8'h71; wr_last = 1'b1; rd_done = 1'b1;
    tick;
    wr_en = 1'b0; wr_last = 1'b0; rd_done = 1'b0;
    chk("swap_valid", rd_bank_valid, 1);
    chk("swap_len", rd_len, 2);
    chk("swap_wr_ready", wr_ready, 1);
    rd(2'd0, 1'b0);
    chk("swap_row0", rd_data, 32'hA3527170);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
